// File: rtl/dmux16_stream.sv
// dmux16_stream -- one input stream steered into two independent output FIFOs.
//
// Each input word is written to the FIFO that SEL picks while the word is on
// IN: SEL=0 picks channel A and SEL=1 picks channel B. Each channel shows its
// oldest word on its output port. A channel's port reads as zero while that
// channel is empty.
//
// Ports
//   CLK       in   clock; all state updates on the rising edge
//   RESET     in   asynchronous active-high reset
//   IN        in   WIDTH  input word
//   SEL       in   destination select (0 = A, 1 = B)
//   IN_VALID  in   IN/SEL valid this cycle
//   IN_READY  out  the channel selected by SEL can take a word
//   A         out  WIDTH  channel A head word (zero when empty)
//   A_VALID   out  channel A is non-empty (registered)
//   A_READY   in   consumer pops channel A
//   B         out  WIDTH  channel B head word (zero when empty)
//   B_VALID   out  channel B is non-empty (registered)
//   B_READY   in   consumer pops channel B
module dmux16_stream #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic [WIDTH-1:0] IN,
   input  logic             SEL,
   input  logic             IN_VALID,
   output logic             IN_READY,
   output logic [WIDTH-1:0] A,
   output logic             A_VALID,
   input  logic             A_READY,
   output logic [WIDTH-1:0] B,
   output logic             B_VALID,
   input  logic             B_READY
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [1:0]            ready_in;
   logic [1:0]            valid;
   logic [1:0]            full;
   logic [1:0]            push;
   logic [1:0]            pop;
   logic [1:0][WIDTH-1:0] head;

   assign ready_in = {B_READY, A_READY};

   // Readiness depends only on SEL and the registered fullness flags. It does
   // not depend on the consumer readies. A pop on a full channel therefore
   // frees the slot only from the next cycle onward.
   assign IN_READY = ~RESET & ~full[SEL];

   for (genvar gi = 0; gi < 2; gi++) begin : g_ch
      localparam logic CH = (gi == 1);

      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_q;
      logic [PTR_W-1:0] rd_ptr_q;
      logic [CNT_W-1:0] count_q;
      logic [CNT_W-1:0] count_d;
      logic             valid_q;

      assign push[gi] = IN_VALID & IN_READY & (SEL == CH);
      assign pop[gi]  = valid_q & ready_in[gi];
      assign full[gi] = (count_q == FULL_CNT);

      always_comb begin
         count_d = count_q;
         case ({push[gi], pop[gi]})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      // DEPTH is a power of two, so the pointers wrap from DEPTH-1 to 0 by
      // ordinary overflow.
      always_ff @(posedge CLK or posedge RESET) begin
         if (RESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
         end else begin
            if (push[gi]) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop[gi])  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_d;
            valid_q <= (count_d != '0);
         end
      end

      // The storage needs no reset. Reset empties the channel through the
      // count, and the output gating hides any stale contents.
      always_ff @(posedge CLK) begin
         if (push[gi]) mem_q[wr_ptr_q] <= IN;
      end

      assign valid[gi] = valid_q;
      assign head[gi]  = valid_q ? mem_q[rd_ptr_q] : '0;
   end

   assign A       = head[0];
   assign A_VALID = valid[0];
   assign B       = head[1];
   assign B_VALID = valid[1];

endmodule

// File: tb/tb_dmux16_stream.sv
// Self-checking bench for dmux16_stream.
// The reference model keeps one queue per channel, bounded to DEPTH entries.
module tb_dmux16_stream;

   localparam int WIDTH = 16;
   localparam int DEPTH = 2;

   logic             clk;
   logic             rst;
   logic [WIDTH-1:0] in_data;
   logic             sel;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a_data;
   logic             a_valid;
   logic             a_ready;
   logic [WIDTH-1:0] b_data;
   logic             b_valid;
   logic             b_ready;

   int checks   = 0;
   int failures = 0;
   bit verbose  = 1'b1;

   logic [WIDTH-1:0] qa[$];
   logic [WIDTH-1:0] qb[$];

   dmux16_stream #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK      (clk),
      .RESET    (rst),
      .IN       (in_data),
      .SEL      (sel),
      .IN_VALID (in_valid),
      .IN_READY (in_ready),
      .A        (a_data),
      .A_VALID  (a_valid),
      .A_READY  (a_ready),
      .B        (b_data),
      .B_VALID  (b_valid),
      .B_READY  (b_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic drive(input logic [WIDTH-1:0] d, input logic s, input logic v,
                        input logic ar, input logic br);
      in_data  = d;
      sel      = s;
      in_valid = v;
      a_ready  = ar;
      b_ready  = br;
   endtask

   // Advance one clock edge. The reference queues are updated with the same
   // accept and pop decisions that the design is expected to make.
   task automatic advance();
      logic acc;
      logic popa;
      logic popb;
      logic [WIDTH-1:0] d;
      logic s;
      acc  = in_valid && (sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH));
      popa = a_ready && (qa.size() != 0);
      popb = b_ready && (qb.size() != 0);
      d    = in_data;
      s    = sel;
      @(posedge clk);
      if (popa) begin
         if (verbose) $display("[%0t] pop  A data=%h", $time, qa[0]);
         void'(qa.pop_front());
      end
      if (popb) begin
         if (verbose) $display("[%0t] pop  B data=%h", $time, qb[0]);
         void'(qb.pop_front());
      end
      if (acc) begin
         if (verbose) $display("[%0t] push %s data=%h", $time, s ? "B" : "A", d);
         if (s) qb.push_back(d);
         else   qa.push_back(d);
      end
      @(negedge clk);
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      qa.delete();
      qb.delete();
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL reset_a_valid got=%b exp=0", a_valid); end
      checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL reset_b_valid got=%b exp=0", b_valid); end
      checks++; if (a_data !== 16'h0) begin failures++; $display("FAIL reset_a got=%h exp=0000", a_data); end
      checks++; if (b_data !== 16'h0) begin failures++; $display("FAIL reset_b got=%h exp=0000", b_data); end
      rst = 1'b0;
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      qa.delete();
      qb.delete();
   endtask

   task automatic test_single();
      apply_reset();
      drive(16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL single_in_ready got=%b exp=1", in_ready); end
      advance();
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      #1;
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL single_a_valid got=%b exp=1", a_valid); end
      checks++; if (a_data !== 16'h1234) begin failures++; $display("FAIL single_a got=%h exp=1234", a_data); end
      checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL single_b_valid got=%b exp=0", b_valid); end
      checks++; if (b_data !== 16'h0000) begin failures++; $display("FAIL single_b got=%h exp=0000", b_data); end
      advance();
   endtask

   task automatic test_full_a();
      apply_reset();
      drive(16'h0001, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_rdy1 got=%b exp=1", in_ready); end
      advance();
      drive(16'h0002, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_rdy2 got=%b exp=1", in_ready); end
      advance();
      drive(16'h0003, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_rdy3 got=%b exp=0", in_ready); end
      advance();
      // Pop on a full channel completes, but the slot opens only next cycle.
      drive(16'h0003, 1'b0, 1'b1, 1'b1, 1'b0); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL full_rdy_pop got=%b exp=0", in_ready); end
      checks++; if (a_data !== 16'h0001) begin failures++; $display("FAIL full_head1 got=%h exp=0001", a_data); end
      advance();
      #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL full_rdy_after got=%b exp=1", in_ready); end
      checks++; if (a_data !== 16'h0002) begin failures++; $display("FAIL full_head2 got=%h exp=0002", a_data); end
      advance();
      drive('0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL full_a_valid3 got=%b exp=1", a_valid); end
      checks++; if (a_data !== 16'h0003) begin failures++; $display("FAIL full_head3 got=%h exp=0003", a_data); end
      advance();
      #1;
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL full_a_empty got=%b exp=0", a_valid); end
      checks++; if (a_data !== 16'h0000) begin failures++; $display("FAIL full_a_zero got=%h exp=0000", a_data); end
   endtask

   task automatic test_cross();
      apply_reset();
      drive(16'h1111, 1'b0, 1'b1, 1'b0, 1'b0); advance();
      drive(16'h2222, 1'b0, 1'b1, 1'b0, 1'b0); advance();
      drive(16'hBEEF, 1'b1, 1'b1, 1'b0, 1'b0); #1;
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cross_rdy_b got=%b exp=1", in_ready); end
      advance();
      drive('0, 1'b0, 1'b1, 1'b0, 1'b0); #1;
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL cross_rdy_a_full got=%b exp=0", in_ready); end
      checks++; if (b_valid !== 1'b1) begin failures++; $display("FAIL cross_b_valid got=%b exp=1", b_valid); end
      checks++; if (b_data !== 16'hBEEF) begin failures++; $display("FAIL cross_b got=%h exp=beef", b_data); end
      checks++; if (a_data !== 16'h1111) begin failures++; $display("FAIL cross_a got=%h exp=1111", a_data); end
      // Push into B while popping A in the same cycle.
      drive(16'hCAFE, 1'b1, 1'b1, 1'b1, 1'b0); advance();
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      checks++; if (a_data !== 16'h2222) begin failures++; $display("FAIL cross_a2 got=%h exp=2222", a_data); end
      checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL cross_rdy_a_free got=%b exp=1", in_ready); end
      drive('0, 1'b1, 1'b0, 1'b0, 1'b1); advance(); #1;
      checks++; if (b_data !== 16'hCAFE) begin failures++; $display("FAIL cross_b2 got=%h exp=cafe", b_data); end
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] exp;
      apply_reset();
      drive(16'h00AA, 1'b0, 1'b1, 1'b0, 1'b0); advance();
      exp = 16'h00AA;
      for (int i = 0; i < 8; i++) begin
         drive(16'h00B0 + 16'(i), 1'b0, 1'b1, 1'b1, 1'b0); #1;
         checks++; if (a_valid !== 1'b1) begin failures++; $display("FAIL b2b_valid i=%0d got=%b exp=1", i, a_valid); end
         checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL b2b_rdy i=%0d got=%b exp=1", i, in_ready); end
         checks++; if (a_data !== exp) begin failures++; $display("FAIL b2b_data i=%0d got=%h exp=%h", i, a_data, exp); end
         advance();
         exp = 16'h00B0 + 16'(i);
      end
      drive('0, 1'b0, 1'b0, 1'b1, 1'b0); #1;
      checks++; if (a_data !== 16'h00B7) begin failures++; $display("FAIL b2b_last got=%h exp=00b7", a_data); end
      advance(); #1;
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b exp=0", a_valid); end
   endtask

   task automatic test_async_reset();
      apply_reset();
      drive(16'h7777, 1'b0, 1'b1, 1'b0, 1'b0); advance();
      drive(16'h8888, 1'b1, 1'b1, 1'b0, 1'b0); advance();
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      #2;
      rst = 1'b1;
      qa.delete();
      qb.delete();
      #1;
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL areset_a_valid got=%b exp=0", a_valid); end
      checks++; if (b_valid !== 1'b0) begin failures++; $display("FAIL areset_b_valid got=%b exp=0", b_valid); end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL areset_in_ready got=%b exp=0", in_ready); end
      checks++; if (a_data !== 16'h0 || b_data !== 16'h0) begin failures++; $display("FAIL areset_data got=%h/%h exp=0000/0000", a_data, b_data); end
      @(negedge clk);
      rst = 1'b0;
      drive(16'h5555, 1'b1, 1'b1, 1'b0, 1'b0); advance();
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
      checks++; if (b_data !== 16'h5555 || b_valid !== 1'b1) begin failures++; $display("FAIL areset_first got=%h/%b exp=5555/1", b_data, b_valid); end
      checks++; if (a_valid !== 1'b0) begin failures++; $display("FAIL areset_a_stale got=%b exp=0", a_valid); end
   endtask

   task automatic test_random();
      logic             exp_rdy;
      logic [WIDTH-1:0] exp_a;
      logic [WIDTH-1:0] exp_b;
      int               bias;
      apply_reset();
      verbose = 1'b0;
      for (int cyc = 0; cyc < 10000; cyc++) begin
         // Alternate between drain-friendly and back-pressure-heavy phases.
         bias = ((cyc / 500) % 2 == 0) ? 8 : 3;
         drive(16'($urandom), 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 7),
               ($urandom_range(0, 9) < bias), ($urandom_range(0, 9) < bias));
         #1;
         exp_rdy = sel ? (qb.size() < DEPTH) : (qa.size() < DEPTH);
         exp_a   = (qa.size() != 0) ? qa[0] : '0;
         exp_b   = (qb.size() != 0) ? qb[0] : '0;
         checks++; if (in_ready !== exp_rdy) begin failures++; $display("FAIL rnd_in_ready cyc=%0d got=%b exp=%b", cyc, in_ready, exp_rdy); end
         checks++; if (a_valid !== (qa.size() != 0)) begin failures++; $display("FAIL rnd_a_valid cyc=%0d got=%b exp=%b", cyc, a_valid, qa.size() != 0); end
         checks++; if (b_valid !== (qb.size() != 0)) begin failures++; $display("FAIL rnd_b_valid cyc=%0d got=%b exp=%b", cyc, b_valid, qb.size() != 0); end
         checks++; if (a_data !== exp_a) begin failures++; $display("FAIL rnd_a cyc=%0d got=%h exp=%h", cyc, a_data, exp_a); end
         checks++; if (b_data !== exp_b) begin failures++; $display("FAIL rnd_b cyc=%0d got=%h exp=%h", cyc, b_data, exp_b); end
         advance();
      end
      verbose = 1'b1;
   endtask

   initial begin
      rst = 1'b1;
      drive('0, 1'b0, 1'b0, 1'b0, 1'b0);
      test_reset();
      test_single();
      test_full_a();
      test_cross();
      test_back_to_back();
      test_async_reset();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
